// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and helpers for the E-stage multiply/divide unit.
// MULDIV_MADD_EN enables the madd/maddu/msub/msubu accumulate ops.
package muldiv_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // Ops that occupy the unit for a multi-cycle RUN phase and raise Busy.
    function automatic logic is_long_op(input logic [3:0] op);
        logic long_op;
        long_op = 1'b0;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: long_op = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: long_op = 1'b1;
`endif
            default: long_op = 1'b0;
        endcase
        return long_op;
    endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Combinational arithmetic core: 64-bit product, quotient/remainder, divide-by-zero flag.
// MULDIV_MADD_EN adds the {HI,LO} +/- product accumulation result.
module muldiv_calc
    import muldiv_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MULDIV_MADD_EN
    input  logic [63:0] acc,
    output logic [63:0] acc_res,
`endif
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic        mult_signed;
    logic        div_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [31:0] b_safe;

    assign mult_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    assign div_signed  = (op == OP_DIV);

    // The low 64 bits of a product of sign-extended operands equal the signed product.
    assign a_ext = mult_signed ? {{32{a[31]}}, a} : {32'd0, a};
    assign b_ext = mult_signed ? {{32{b[31]}}, b} : {32'd0, b};
    assign prod  = a_ext * b_ext;

    assign div_zero = (b == 32'd0);
    assign b_safe   = div_zero ? 32'd1 : b;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        quot = a / b_safe;
        rem  = a % b_safe;
        if (div_signed) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                quot = 32'h8000_0000;
                rem  = 32'd0;
            end else begin
                quot = $signed(a) / $signed(b_safe);
                rem  = $signed(a) % $signed(b_safe);
            end
        end
    end

`ifdef MULDIV_MADD_EN
    assign acc_res = ((op == OP_MSUB) || (op == OP_MSUBU)) ? acc - prod : acc + prod;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// E-stage multiply/divide sequencer with the architectural HI/LO registers.
// MULDIV_MADD_EN enables the accumulate op codes 7-10.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic        state;
    logic [4:0]  count;
    hilo_t       pending;
    logic        accept;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;
`ifdef MULDIV_MADD_EN
    logic [63:0] acc_res;
`endif

    muldiv_calc u_calc (
        .op       (op),
        .a        (A),
        .b        (B),
`ifdef MULDIV_MADD_EN
        .acc      ({HI, LO}),
        .acc_res  (acc_res),
`endif
        .prod     (prod),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    assign accept = start && !cancel && (state == ST_IDLE);
    // Combinational so the D-stage instruction stalls in the very cycle the op is issued.
    assign Busy   = (start && !cancel && is_long_op(op)) || (state == ST_RUN);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state   <= ST_IDLE;
            count   <= 5'd0;
            pending <= '0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                case (op)
                    OP_MTHI: HI <= A;
                    OP_MTLO: LO <= A;
                    OP_MULT, OP_MULTU: begin
                        pending <= prod;
                        count   <= 5'(MULT_CYCLES);
                        state   <= ST_RUN;
                    end
                    OP_DIV, OP_DIVU: begin
                        // A zero divisor re-commits the current HI/LO but still takes full latency.
                        pending <= div_zero ? {HI, LO} : {rem, quot};
                        count   <= 5'(DIV_CYCLES);
                        state   <= ST_RUN;
                    end
`ifdef MULDIV_MADD_EN
                    OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                        pending <= acc_res;
                        count   <= 5'(MULT_CYCLES);
                        state   <= ST_RUN;
                    end
`endif
                    default: ;
                endcase
            end
        end else begin
            count <= count - 5'd1;
            if (count == 5'd1) begin
                HI    <= pending.hi;
                LO    <= pending.lo;
                state <= ST_IDLE;
            end
        end
    end

`ifndef SYNTHESIS
    // The hazard unit must never issue a new mul/div op while the unit is still running.
    a_no_start_in_run: assert property (@(posedge clk) disable iff (reset)
        !(start && !cancel && state == ST_RUN));
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random ops against a 64-bit arithmetic model.
// Honours MULDIV_MADD_EN the same way the design does.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cancel (cancel),
        .op     (op),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Architectural result of one accepted op, from plain 64-bit arithmetic.
    task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int busy_cycles);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          q;
        longint          r;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        res = {m_hi, m_lo};
        busy_cycles = 0;
        case (o)
            OP_MULT:  begin res = sa * sb; busy_cycles = MULT_N + 1; end
            OP_MULTU: begin res = ua * ub; busy_cycles = MULT_N + 1; end
            OP_DIV: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
                busy_cycles = DIV_N + 1;
            end
            OP_DIVU: begin
                if (b != 0) begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                    res = {r[31:0], q[31:0]};
                end
                busy_cycles = DIV_N + 1;
            end
            OP_MTHI: res[63:32] = a;
            OP_MTLO: res[31:0]  = a;
`ifdef MULDIV_MADD_EN
            OP_MADD:  begin res = res + 64'(sa * sb); busy_cycles = MULT_N + 1; end
            OP_MADDU: begin res = res + 64'(ua * ub); busy_cycles = MULT_N + 1; end
            OP_MSUB:  begin res = res - 64'(sa * sb); busy_cycles = MULT_N + 1; end
            OP_MSUBU: begin res = res - 64'(ua * ub); busy_cycles = MULT_N + 1; end
`endif
            default: ;
        endcase
        m_hi = res[63:32];
        m_lo = res[31:0];
    endtask

    // Issue one op, count Busy cycles (bounded), then compare HI/LO with the model.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        int busy_seen;
        int busy_exp;
        busy_seen = 0;
        model_op(o, a, b, busy_exp);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        #1;
        if (Busy) busy_seen++;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        #1;
        for (int i = 0; i < 64 && Busy; i++) begin
            busy_seen++;
            @(negedge clk);
            #1;
        end
        check({tag, " busy"}, 64'(busy_seen), 64'(busy_exp));
        check({tag, " HI"}, 64'(HI), 64'(m_hi));
        check({tag, " LO"}, 64'(LO), 64'(m_lo));
    endtask

    initial begin
        int          sel;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = OP_NONE; A = '0; B = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset Busy", 64'(Busy), 64'd0);
        check("reset HI", 64'(HI), 64'd0);
        check("reset LO", 64'(LO), 64'd0);
        reset = 1'b0;

        run_op("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3);
        check("mult HI const", 64'(HI), 64'hFFFF_FFFF);
        check("mult LO const", 64'(LO), 64'hFFFF_FFFA);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        check("multu HI const", 64'(HI), 64'h0000_0002);
        run_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2);
        check("div LO const", 64'(LO), 64'hFFFF_FFFD);
        check("div HI const", 64'(HI), 64'hFFFF_FFFF);
        run_op("divu0", OP_DIVU,  32'd7, 32'd0);
        run_op("divovf", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf LO const", 64'(LO), 64'h8000_0000);

        // mthi then mtlo on back-to-back cycles
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; A = 32'h1234_5678;
        #1;
        check("mthi Busy", 64'(Busy), 64'd0);
        @(negedge clk);
        op = OP_MTLO; A = 32'h9;
        #1;
        check("mtlo Busy", 64'(Busy), 64'd0);
        check("mthi HI", 64'(HI), 64'h1234_5678);
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        #1;
        check("mtlo LO", 64'(LO), 64'h9);
        m_hi = 32'h1234_5678; m_lo = 32'h9;

        // cancelled start is ignored
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = OP_MULT; A = 32'd100; B = 32'd200;
        #1;
        check("cancel Busy", 64'(Busy), 64'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; op = OP_NONE;
        #1;
        check("cancel no RUN", 64'(Busy), 64'd0);
        check("cancel HI", 64'(HI), 64'(m_hi));
        check("cancel LO", 64'(LO), 64'(m_lo));

        // cancel during RUN has no effect
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; A = 32'd6; B = 32'd7;
        @(negedge clk);
        start = 1'b0; op = OP_NONE; cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        repeat (MULT_N) @(negedge clk);
        #1;
        check("cancel-run Busy", 64'(Busy), 64'd0);
        check("cancel-run LO", 64'(LO), 64'd42);
        check("cancel-run HI", 64'(HI), 64'd0);
        m_hi = 32'd0; m_lo = 32'd42;

        // reset in the third RUN cycle of a div aborts without commit
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("abort Busy", 64'(Busy), 64'd0);
        check("abort HI", 64'(HI), 64'd0);
        check("abort LO", 64'(LO), 64'd0);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        run_op("post-reset mult", OP_MULT, 32'd1000, 32'hFFFF_FFFF);

`ifdef MULDIV_MADD_EN
        run_op("set HI", OP_MTHI, 32'd0, 32'd0);
        run_op("set LO", OP_MTLO, 32'hFFFF_FFFF, 32'd0);
        run_op("maddu", OP_MADDU, 32'd1, 32'd1);
        check("maddu HI const", 64'(HI), 64'd1);
        check("maddu LO const", 64'(LO), 64'd0);
`endif

        for (int n = 0; n < 60; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 9));
            run_op("rand", rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
